// File: rtl/btb_predictor_pkg.sv
// rtl/btb_predictor_pkg.sv - shared constants, state type and counter helpers for the BTB predictor
// Contents: default WORD_SIZE, FSM state type (ST_INIT / ST_READY),
//           saturating-counter level helpers as functions of CNT_BITS.
package btb_predictor_pkg;

   localparam int WORD_SIZE = 16;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } btb_state_t;

   // Counter levels: the MSB of the counter is the taken/not-taken decision,
   // so WEAK_T is the smallest value with the MSB set.
   function automatic int cnt_max(input int cnt_bits);
      return (1 << cnt_bits) - 1;
   endfunction

   function automatic int weak_t(input int cnt_bits);
      return 1 << (cnt_bits - 1);
   endfunction

   function automatic int weak_nt(input int cnt_bits);
      return (1 << (cnt_bits - 1)) - 1;
   endfunction

endpackage

// File: rtl/btb_predictor_sat_counter.sv
// rtl/btb_predictor_sat_counter.sv - next value of a saturating up/down counter
// Ports:
//   cnt      in  current counter value
//   inc      in  1 = count up (stops at all-ones), 0 = count down (stops at zero)
//   cnt_next out saturated next value
module btb_predictor_sat_counter #(
   parameter int CNT_BITS = 2
) (
   input  logic [CNT_BITS-1:0] cnt,
   input  logic                inc,
   output logic [CNT_BITS-1:0] cnt_next
);

   always_comb begin
      cnt_next = cnt;
      if (inc) begin
         if (cnt != '1) cnt_next = cnt + CNT_BITS'(1);
      end else begin
         if (cnt != '0) cnt_next = cnt - CNT_BITS'(1);
      end
   end

endmodule

// File: rtl/btb_predictor.sv
// rtl/btb_predictor.sv - tagged BTB next-PC predictor with per-entry counters and optional gshare
// Ports:
//   clk, reset (sync, active-high)
//   pc               in  fetch PC;  pred_next_pc / pred_taken / pred_hit out (combinational)
//   init_busy        out table clear in progress
//   upd_valid, upd_pc, upd_is_branch, upd_taken, upd_target  in  resolve-stage update port
module btb_predictor
   import btb_predictor_pkg::*;
#(
   parameter int WORD_SIZE  = btb_predictor_pkg::WORD_SIZE,
   parameter int INDEX_BITS = 8,
   parameter int CNT_BITS   = 2,
   parameter int USE_GSHARE = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WORD_SIZE-1:0] pc,
   output logic [WORD_SIZE-1:0] pred_next_pc,
   output logic                 pred_taken,
   output logic                 pred_hit,
   output logic                 init_busy,
   input  logic                 upd_valid,
   input  logic [WORD_SIZE-1:0] upd_pc,
   input  logic                 upd_is_branch,
   input  logic                 upd_taken,
   input  logic [WORD_SIZE-1:0] upd_target
);

   localparam int ENTRIES  = 1 << INDEX_BITS;
   localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
   localparam logic [CNT_BITS-1:0] C_MAX     = CNT_BITS'(cnt_max(CNT_BITS));
   localparam logic [CNT_BITS-1:0] C_WEAK_T  = CNT_BITS'(weak_t(CNT_BITS));
   localparam logic [CNT_BITS-1:0] C_WEAK_NT = CNT_BITS'(weak_nt(CNT_BITS));

   logic                  valid_q  [ENTRIES];
   logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
   logic [WORD_SIZE-1:0]  target_q [ENTRIES];
   logic [CNT_BITS-1:0]   cnt_q    [ENTRIES];

   btb_state_t            state_q, state_d;
   logic [INDEX_BITS-1:0] init_idx_q, init_idx_d;
   logic [INDEX_BITS-1:0] ghr_q, ghr_d;

   logic [INDEX_BITS-1:0] hist;
   logic [INDEX_BITS-1:0] l_idx, u_idx;
   logic [TAG_BITS-1:0]   u_tag;
   logic                  u_hit;
   logic [CNT_BITS-1:0]   cnt_sat;

   logic                  wr_en, wr_valid, ghr_shift;
   logic [INDEX_BITS-1:0] wr_idx;
   logic [TAG_BITS-1:0]   wr_tag;
   logic [WORD_SIZE-1:0]  wr_target;
   logic [CNT_BITS-1:0]   wr_cnt;

   assign hist      = (USE_GSHARE != 0) ? ghr_q : '0;
   assign l_idx     = pc[INDEX_BITS-1:0] ^ hist;
   assign u_idx     = upd_pc[INDEX_BITS-1:0] ^ hist;
   assign u_tag     = upd_pc[WORD_SIZE-1:INDEX_BITS];
   assign u_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign init_busy = (state_q == ST_INIT);

   // Lookup reads the table as it stands before this edge's write: no bypass.
   always_comb begin
      pred_hit     = 1'b0;
      pred_taken   = 1'b0;
      pred_next_pc = pc + WORD_SIZE'(1);
      if (state_q == ST_READY) begin
         pred_hit   = valid_q[l_idx] && (tag_q[l_idx] == pc[WORD_SIZE-1:INDEX_BITS]);
         pred_taken = pred_hit && cnt_q[l_idx][CNT_BITS-1];
         if (pred_taken) pred_next_pc = target_q[l_idx];
      end
   end

   btb_predictor_sat_counter #(.CNT_BITS(CNT_BITS)) u_sat_counter (
      .cnt      (cnt_q[u_idx]),
      .inc      (upd_taken),
      .cnt_next (cnt_sat)
   );

   // Single write port, shared between the init sweep and resolve updates.
   always_comb begin
      wr_en     = 1'b0;
      wr_idx    = init_idx_q;
      wr_valid  = 1'b0;
      wr_tag    = '0;
      wr_target = '0;
      wr_cnt    = C_WEAK_NT;
      ghr_shift = 1'b0;
      if (!reset) begin
         if (state_q == ST_INIT) begin
            wr_en = 1'b1;
         end else if (upd_valid) begin
            wr_idx   = u_idx;
            wr_valid = 1'b1;
            wr_tag   = u_tag;
            if (upd_is_branch) begin
               ghr_shift = 1'b1;
               if (u_hit) begin
                  wr_en     = 1'b1;
                  wr_cnt    = cnt_sat;
                  wr_target = upd_taken ? upd_target : target_q[u_idx];
               end else if (upd_taken) begin
                  wr_en     = 1'b1;
                  wr_cnt    = C_WEAK_T;
                  wr_target = upd_target;
               end
            end else begin
               wr_en     = 1'b1;
               wr_cnt    = C_MAX;
               wr_target = upd_target;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      init_idx_d = init_idx_q;
      ghr_d      = ghr_shift ? {ghr_q[INDEX_BITS-2:0], upd_taken} : ghr_q;
      if (state_q == ST_INIT) begin
         init_idx_d = init_idx_q + INDEX_BITS'(1);
         if (init_idx_q == '1) state_d = ST_READY;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_INIT;
         init_idx_q <= '0;
         ghr_q      <= '0;
      end else begin
         state_q    <= state_d;
         init_idx_q <= init_idx_d;
         ghr_q      <= ghr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         valid_q[wr_idx]  <= wr_valid;
         tag_q[wr_idx]    <= wr_tag;
         target_q[wr_idx] <= wr_target;
         cnt_q[wr_idx]    <= wr_cnt;
      end
   end

endmodule

// File: tb/tb_btb_predictor.sv
// tb/tb_btb_predictor.sv - scoreboard bench for btb_predictor (plain and gshare instances)
module tb_btb_predictor;

   localparam int NENT = 256;
   localparam int CMAX = 3;
   localparam int WT   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] pc = '0, upd_pc = '0, upd_target = '0;
   logic        upd_valid = 1'b0, upd_is_branch = 1'b0, upd_taken = 1'b0;

   logic [15:0] nx0, nx1;
   logic        tk0, tk1, hit0, hit1, bz0, bz1;

   always #5 clk = ~clk;

   btb_predictor #(.WORD_SIZE(16), .INDEX_BITS(8), .CNT_BITS(2), .USE_GSHARE(0)) u_plain (
      .clk(clk), .reset(reset), .pc(pc), .pred_next_pc(nx0), .pred_taken(tk0),
      .pred_hit(hit0), .init_busy(bz0), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_is_branch(upd_is_branch), .upd_taken(upd_taken), .upd_target(upd_target));

   btb_predictor #(.WORD_SIZE(16), .INDEX_BITS(8), .CNT_BITS(2), .USE_GSHARE(1)) u_gshare (
      .clk(clk), .reset(reset), .pc(pc), .pred_next_pc(nx1), .pred_taken(tk1),
      .pred_hit(hit1), .init_busy(bz1), .upd_valid(upd_valid), .upd_pc(upd_pc),
      .upd_is_branch(upd_is_branch), .upd_taken(upd_taken), .upd_target(upd_target));

   typedef struct {
      bit          nochk;
      bit          busy;
      bit          hit;
      bit          taken;
      logic [15:0] nxt;
      string       name;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model: plain arrays, k=0 plain indexing, k=1 gshare indexing.
   bit mv   [2][NENT];
   int mtag [2][NENT];
   int mtgt [2][NENT];
   int mcnt [2][NENT];
   int mghr [2];
   int init_left [2];
   bit mknown = 1'b0;

   logic [15:0] pool [12] = '{16'h1234, 16'h2234, 16'h0034, 16'h0040, 16'h0140, 16'h00FF,
                              16'hFFFF, 16'h0010, 16'h0011, 16'h1010, 16'h0300, 16'h0205};

   function automatic int midx(int k, logic [15:0] p);
      return (int'(p) % NENT) ^ ((k == 1) ? mghr[k] : 0);
   endfunction

   function automatic exp_t model_look(int k, logic [15:0] p, string nm);
      exp_t e;
      int   i;
      e.nochk = !mknown;
      e.name  = nm;
      e.busy  = (init_left[k] > 0);
      e.hit   = 1'b0;
      e.taken = 1'b0;
      e.nxt   = 16'((int'(p) + 1) % 65536);
      if (!e.busy) begin
         i = midx(k, p);
         if (mv[k][i] && mtag[k][i] == int'(p) / NENT) begin
            e.hit = 1'b1;
            if (mcnt[k][i] >= WT) begin
               e.taken = 1'b1;
               e.nxt   = 16'(mtgt[k][i]);
            end
         end
      end
      return e;
   endfunction

   task automatic model_edge(bit rst, bit uv, logic [15:0] up, bit ub, bit ut, logic [15:0] tg);
      int i, t;
      bit h;
      if (rst) mknown = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            init_left[k] = NENT;
            mghr[k] = 0;
            for (int j = 0; j < NENT; j++) mv[k][j] = 1'b0;
         end else if (init_left[k] > 0) begin
            init_left[k]--;
         end else if (uv) begin
            i = midx(k, up);
            t = int'(up) / NENT;
            h = mv[k][i] && mtag[k][i] == t;
            if (ub) begin
               if (h) begin
                  if (ut) begin
                     mcnt[k][i] = (mcnt[k][i] < CMAX) ? mcnt[k][i] + 1 : CMAX;
                     mtgt[k][i] = int'(tg);
                  end else begin
                     mcnt[k][i] = (mcnt[k][i] > 0) ? mcnt[k][i] - 1 : 0;
                  end
               end else if (ut) begin
                  mv[k][i] = 1'b1; mtag[k][i] = t; mtgt[k][i] = int'(tg); mcnt[k][i] = WT;
               end
               mghr[k] = (mghr[k] * 2 + int'(ut)) % NENT;
            end else begin
               mv[k][i] = 1'b1; mtag[k][i] = t; mtgt[k][i] = int'(tg); mcnt[k][i] = CMAX;
            end
         end
      end
   endtask

   // One clock of stimulus. c0/c1 replace the model's hit/taken/next with the
   // hand-derived constants (ch, ctk, cn) for that instance.
   task automatic step(bit rst, logic [15:0] p, bit uv, logic [15:0] up, bit ub, bit ut,
                       logic [15:0] tg, string nm, bit c0 = 0, bit c1 = 0,
                       bit ch = 0, bit ctk = 0, logic [15:0] cn = 16'h0);
      exp_t e0, e1;
      reset = rst; pc = p; upd_valid = uv; upd_pc = up;
      upd_is_branch = ub; upd_taken = ut; upd_target = tg;
      e0 = model_look(0, p, nm);
      e1 = model_look(1, p, nm);
      if (c0) begin e0.hit = ch; e0.taken = ctk; e0.nxt = cn; end
      if (c1) begin e1.hit = ch; e1.taken = ctk; e1.nxt = cn; end
      q0.push_back(e0);
      q1.push_back(e1);
      @(posedge clk);
      model_edge(rst, uv, up, ub, ut, tg);
      #1;
   endtask

   task automatic cmp(int k, string nm, string fld, logic [15:0] got, logic [15:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s inst%0d %s: got %h want %h", nm, k, fld, got, want);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q0.size() > 0) begin
         e = q0.pop_front();
         if (!e.nochk) begin
            cmp(0, e.name, "init_busy", 16'(bz0), 16'(e.busy));
            cmp(0, e.name, "pred_hit", 16'(hit0), 16'(e.hit));
            cmp(0, e.name, "pred_taken", 16'(tk0), 16'(e.taken));
            cmp(0, e.name, "pred_next_pc", nx0, e.nxt);
         end
      end
      if (q1.size() > 0) begin
         e = q1.pop_front();
         if (!e.nochk) begin
            cmp(1, e.name, "init_busy", 16'(bz1), 16'(e.busy));
            cmp(1, e.name, "pred_hit", 16'(hit1), 16'(e.hit));
            cmp(1, e.name, "pred_taken", 16'(tk1), 16'(e.taken));
            cmp(1, e.name, "pred_next_pc", nx1, e.nxt);
         end
      end
   end

   function automatic logic [15:0] pick();
      if ($urandom_range(0, 3) == 0) return 16'($urandom);
      return pool[$urandom_range(0, 11)];
   endfunction

   initial begin
      @(posedge clk);
      #1;
      step(1, 16'h0010, 0, 0, 0, 0, 0, "reset");
      for (int i = 0; i < NENT; i++) begin
         if (i == 5)
            step(0, 16'h0010, 1, 16'h1234, 1, 1, 16'h1200, "init_upd", 1, 1, 0, 0, 16'h0011);
         else if (i == 9)
            step(0, 16'h0010, 1, 16'h0010, 0, 1, 16'h0099, "init_jmp", 1, 1, 0, 0, 16'h0011);
         else
            step(0, 16'h0010, 0, 0, 0, 0, 0, "init", 1, 1, 0, 0, 16'h0011);
      end
      step(0, 16'h1234, 0, 0, 0, 0, 0, "post_init_1234", 1, 1, 0, 0, 16'h1235);
      step(0, 16'h0010, 0, 0, 0, 0, 0, "post_init_0010", 1, 1, 0, 0, 16'h0011);

      step(0, 16'h0000, 1, 16'h1234, 1, 1, 16'h1200, "alloc");
      step(0, 16'h1234, 0, 0, 0, 0, 0, "alloc_hit", 1, 0, 1, 1, 16'h1200);
      step(0, 16'h1234, 1, 16'h1234, 1, 0, 0, "detrain1");
      step(0, 16'h1234, 1, 16'h1234, 1, 0, 0, "detrain2");
      step(0, 16'h1234, 0, 0, 0, 0, 0, "detrained", 1, 0, 1, 0, 16'h1235);

      for (int i = 0; i < 5; i++) step(0, 16'h0000, 1, 16'h0040, 1, 1, 16'h0080, "sat_up");
      step(0, 16'h0000, 1, 16'h0040, 1, 0, 0, "sat_nt");
      step(0, 16'h0040, 0, 0, 0, 0, 0, "sat_hi", 1, 0, 1, 1, 16'h0080);
      for (int i = 0; i < 3; i++) step(0, 16'h0000, 1, 16'h0040, 1, 0, 0, "sat_down");
      step(0, 16'h0000, 1, 16'h0040, 1, 1, 16'h0080, "sat_t");
      step(0, 16'h0040, 0, 0, 0, 0, 0, "sat_lo", 1, 0, 1, 0, 16'h0041);

      step(0, 16'h0000, 1, 16'h0105, 1, 1, 16'h0050, "conf_alloc");
      step(0, 16'h0000, 1, 16'h0205, 0, 1, 16'h0777, "conf_jump");
      step(0, 16'h0105, 0, 0, 0, 0, 0, "conf_old", 1, 0, 0, 0, 16'h0106);
      step(0, 16'h0205, 0, 0, 0, 0, 0, "conf_new", 1, 0, 1, 1, 16'h0777);

      step(0, 16'h0300, 1, 16'h0300, 1, 1, 16'h0310, "hazard_same", 1, 0, 0, 0, 16'h0301);
      step(0, 16'h0300, 0, 0, 0, 0, 0, "hazard_next", 1, 0, 1, 1, 16'h0310);
      step(0, 16'hFFFF, 0, 0, 0, 0, 0, "wrap", 1, 0, 0, 0, 16'h0000);

      step(1, 16'h1234, 0, 0, 0, 0, 0, "mid_reset");
      for (int i = 0; i < NENT; i++)
         step(0, pick(), 1, pick(), 1'($urandom), 1'($urandom), 16'($urandom), "reinit");
      step(0, 16'h1234, 0, 0, 0, 0, 0, "cleared_1234", 1, 1, 0, 0, 16'h1235);
      step(0, 16'h0040, 0, 0, 0, 0, 0, "cleared_0040", 1, 1, 0, 0, 16'h0041);
      step(0, 16'h0205, 0, 0, 0, 0, 0, "cleared_0205", 1, 1, 0, 0, 16'h0206);

      step(0, 16'h0000, 1, 16'h0500, 1, 1, 16'h0600, "gs_hist");
      step(0, 16'h0000, 1, 16'h0010, 0, 1, 16'h0ABC, "gs_jump");
      step(0, 16'h0010, 0, 0, 0, 0, 0, "gs_hit", 1, 1, 1, 1, 16'h0ABC);
      step(0, 16'h0011, 0, 0, 0, 0, 0, "gs_idx11_other_tag");

      for (int i = 0; i < 1500; i++)
         step(($urandom_range(0, 599) == 0), pick(), 1'($urandom), pick(),
              ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom), "random");

      reset = 1'b0; upd_valid = 1'b0;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
